// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface.
// A single-port RAM sits behind a four-phase Read/Write request and done handshake,
// with a configurable number of wait states before each access.
// Address and write data are captured on the request edge. Read data returns on rdata.
module mem_responder #(
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              Read,
   input  logic              Write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              op_wr_q;

   // Next-state logic: the request is taken only from IDLE. In HOLD the FSM waits for both request lines to drop.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (Read || Write) begin
               cnt_nxt   = WAIT_LD;
               state_nxt = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt <= 4'd1) begin
               cnt_nxt   = 4'd0;
               state_nxt = S_ACCESS;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_ACCESS: begin
            state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (!Read && !Write)
               state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Control state and registered outputs. An abort in reset drops any pending access before its commit edge.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
         busy  <= 1'b0;
         done  <= 1'b0;
         rdata <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         busy  <= (state_nxt != S_IDLE);
         done  <= (state_nxt == S_HOLD);
         if (state == S_ACCESS && !op_wr_q)
            rdata <= mem[addr_q];
      end
   end

   // Request capture: address, data and operation are frozen for the whole transaction. Write wins over Read.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && (Read || Write)) begin
         addr_q  <= addr;
         wdata_q <= wdata;
         op_wr_q <= Write;
      end
   end

   // RAM write port: commits only on the single ACCESS cycle of a write.
   always_ff @(posedge clk) begin
      if (state == S_ACCESS && op_wr_q)
         mem[addr_q] <= wdata_q;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder.
// The main instance uses two wait states, and a second instance uses zero wait states.
module tb_mem_responder;

   logic        clk;
   logic        clr, Read, Write;
   logic [8:0]  addr;
   logic [31:0] wdata, rdata;
   logic        busy, done;

   logic        clr0, rd0, wr0;
   logic [8:0]  a0;
   logic [31:0] d0, rdata0;
   logic        busy0, done0;

   int vectors = 0;
   int errors  = 0;

   mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(2)) dut (
      .clk(clk), .clr(clr), .Read(Read), .Write(Write), .addr(addr), .wdata(wdata),
      .rdata(rdata), .busy(busy), .done(done)
   );

   mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .clr(clr0), .Read(rd0), .Write(wr0), .addr(a0), .wdata(d0),
      .rdata(rdata0), .busy(busy0), .done(done0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Raise a request on the main instance, then scramble addr and wdata once it is taken.
   // The task counts edges until done and checks the edge count.
   task automatic xact(input string tag, input logic rd, input logic wr,
                       input logic [8:0] a, input logic [31:0] d, input int exp_lat);
      int lat;
      Read  = rd;
      Write = wr;
      addr  = a;
      wdata = d;
      tick();
      lat = 1;
      check({tag, "_busy_wait"}, {31'd0, busy}, 32'd1);
      addr  = ~a;
      wdata = ~d;
      while (done !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic release_req(input string tag);
      Read  = 1'b0;
      Write = 1'b0;
      tick();
      check({tag, "_done_low"}, {31'd0, done}, 32'd0);
      check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic held_ok;
      clr = 1'b0; Read = 1'b0; Write = 1'b0; addr = '0; wdata = '0;
      clr0 = 1'b0; rd0 = 1'b0; wr0 = 1'b0; a0 = '0; d0 = '0;
      repeat (2) tick();
      check("rst_rdata", rdata, 32'd0);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_done",  {31'd0, done}, 32'd0);
      clr  = 1'b1;
      clr0 = 1'b1;
      tick();

      // Write then read back with two wait states.
      xact("wr_005", 1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 4);
      release_req("wr_005");
      xact("rd_005", 1'b1, 1'b0, 9'h005, 32'h0, 4);
      check("rd_005_data", rdata, 32'hDEADBEEF);
      release_req("rd_005");

      // Both request lines high: the write wins and rdata is left alone.
      xact("both_010", 1'b1, 1'b1, 9'h010, 32'h12345678, 4);
      check("both_010_rdata_kept", rdata, 32'hDEADBEEF);
      release_req("both_010");
      xact("rd_010", 1'b1, 1'b0, 9'h010, 32'h0, 4);
      check("rd_010_data", rdata, 32'h12345678);
      release_req("rd_010");

      // A request held long past done yields one access. done stays up until the request is dropped.
      xact("hold_005", 1'b1, 1'b0, 9'h005, 32'h0, 4);
      held_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done !== 1'b1 || busy !== 1'b1) held_ok = 1'b0;
      end
      check("hold_done_busy_stay", {31'd0, held_ok}, 32'd1);
      check("hold_rdata", rdata, 32'hDEADBEEF);
      release_req("hold_005");

      // Write top and bottom locations. Abort a second write to the top location with reset during WAIT.
      xact("wr_000", 1'b0, 1'b1, 9'h000, 32'h0BADF00D, 4);
      release_req("wr_000");
      xact("wr_1ff", 1'b0, 1'b1, 9'h1FF, 32'hA5A5A5A5, 4);
      release_req("wr_1ff");
      Write = 1'b1;
      addr  = 9'h1FF;
      wdata = 32'hFFFFFFFF;
      tick();
      check("abort_busy_wait", {31'd0, busy}, 32'd1);
      clr = 1'b0;
      #1;
      check("async_rst_rdata", rdata, 32'd0);
      check("async_rst_busy",  {31'd0, busy}, 32'd0);
      check("async_rst_done",  {31'd0, done}, 32'd0);
      Write = 1'b0;
      tick();
      clr = 1'b1;
      tick();
      xact("rd_1ff", 1'b1, 1'b0, 9'h1FF, 32'h0, 4);
      check("rd_1ff_data", rdata, 32'hA5A5A5A5);
      release_req("rd_1ff");
      xact("rd_000", 1'b1, 1'b0, 9'h000, 32'h0, 4);
      check("rd_000_data", rdata, 32'h0BADF00D);
      release_req("rd_000");

      // With zero wait states, busy covers only the ACCESS and HOLD cycles.
      wr0 = 1'b1; a0 = 9'h003; d0 = 32'h13579BDF;
      check("w0_busy_before", {31'd0, busy0}, 32'd0);
      tick();
      check("w0_busy_access", {31'd0, busy0}, 32'd1);
      check("w0_done_access", {31'd0, done0}, 32'd0);
      tick();
      check("w0_done_hold", {31'd0, done0}, 32'd1);
      check("w0_busy_hold", {31'd0, busy0}, 32'd1);
      wr0 = 1'b0;
      tick();
      check("w0_busy_idle", {31'd0, busy0}, 32'd0);
      rd0 = 1'b1;
      tick();
      check("r0_busy_access", {31'd0, busy0}, 32'd1);
      check("r0_done_access", {31'd0, done0}, 32'd0);
      tick();
      check("r0_done_hold", {31'd0, done0}, 32'd1);
      check("r0_data", rdata0, 32'h13579BDF);
      rd0 = 1'b0;
      tick();
      check("r0_busy_idle", {31'd0, busy0}, 32'd0);
      check("r0_done_idle", {31'd0, done0}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
